// File: rtl/mpadder_arbiter.sv
// ---------------------------------------------------------------------------
// mpadder_arbiter
//
// Shares one multi-precision adder/subtractor between two requesters. A
// round-robin choice picks the winner in IDLE. The winner's operands and op
// select are latched there and held constant for the whole operation. The
// arbiter then starts the adder, waits for its done pulse, and returns the
// result with a one-cycle done pulse to the owner. If the adder never answers
// within TIMEOUT cycles, it is flushed through its synchronous reset. The
// owner then gets a done pulse with err_o set and a zero result.
//
// Ports
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   req_i[1:0]       level request per requester (bit 0 = requester 0)
//   sub_i[1:0]       per-requester op select: 1 = a-b, 0 = a+b
//   a0_i, b0_i       operands of requester 0
//   a1_i, b1_i       operands of requester 1
//   gnt_o[1:0]       one-cycle pulse: the owner's operands were latched
//   done_o[1:0]      one-cycle pulse: res_o / err_o are valid for the owner
//   res_o            last result, held until the next completion
//   err_o            1 = the last operation timed out (res_o = 0)
//   busy_o           high whenever the sequencer is not idle
//   adder_start_o    start pulse to the adder
//   adder_sub_o      subtract select to the adder (held for the operation)
//   adder_a_o/b_o    operands to the adder (held for the operation)
//   adder_result_i   adder result
//   adder_done_i     adder done pulse
//   adder_resetn_o   synchronous active-low reset to the adder
// ---------------------------------------------------------------------------
module mpadder_arbiter #(
    parameter int OP_WIDTH = 1027,
    parameter int TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_i,
    input  logic [1:0]          sub_i,
    input  logic [OP_WIDTH-1:0] a0_i,
    input  logic [OP_WIDTH-1:0] b0_i,
    input  logic [OP_WIDTH-1:0] a1_i,
    input  logic [OP_WIDTH-1:0] b1_i,
    output logic [1:0]          gnt_o,
    output logic [1:0]          done_o,
    output logic [OP_WIDTH:0]   res_o,
    output logic                err_o,
    output logic                busy_o,
    output logic                adder_start_o,
    output logic                adder_sub_o,
    output logic [OP_WIDTH-1:0] adder_a_o,
    output logic [OP_WIDTH-1:0] adder_b_o,
    input  logic [OP_WIDTH:0]   adder_result_i,
    input  logic                adder_done_i,
    output logic                adder_resetn_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t           state;
    state_t           stateNext;
    logic [CNT_W-1:0] waitCnt;
    logic [CNT_W-1:0] waitCntNext;
    logic             owner;
    logic             ownerNext;
    logic             lastGnt;
    logic             lastGntNext;
    logic             winner;
    logic             latchEn;

    logic [1:0]       gntNext;
    logic [1:0]       doneNext;
    logic [OP_WIDTH:0] resNext;
    logic             errNext;
    logic             busyNext;
    logic             startNext;
    logic             resetnNext;

    // Round-robin choice: a lone requester always wins. When both request,
    // the one that was not granted last wins. Reset sets lastGnt to 1 so
    // requester 0 wins the first tie.
    always_comb begin
        winner = 1'b0;
        case (req_i)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~lastGnt;
            default: winner = 1'b0;
        endcase
    end

    // Next-state and next-output logic. Every output is registered, so this
    // block computes the values the outputs take after the coming edge.
    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        ownerNext   = owner;
        lastGntNext = lastGnt;
        latchEn     = 1'b0;
        gntNext     = 2'b00;
        doneNext    = 2'b00;
        resNext     = res_o;
        errNext     = err_o;
        startNext   = 1'b0;
        resetnNext  = 1'b1;

        case (state)
            IDLE: begin
                if (|req_i) begin
                    latchEn     = 1'b1;
                    ownerNext   = winner;
                    lastGntNext = winner;
                    gntNext     = winner ? 2'b10 : 2'b01;
                    startNext   = 1'b1;
                    stateNext   = ISSUE;
                end
            end

            ISSUE: begin
                waitCntNext = '0;
                stateNext   = WAIT;
            end

            WAIT: begin
                if (adder_done_i) begin
                    resNext   = adder_result_i;
                    errNext   = 1'b0;
                    doneNext  = owner ? 2'b10 : 2'b01;
                    stateNext = IDLE;
                end else begin
                    waitCntNext = waitCnt + 1'b1;
                    // The WAIT cycle with count TIMEOUT-1 is the last one,
                    // so WAIT lasts exactly TIMEOUT cycles.
                    if (waitCnt == CNT_W'(TIMEOUT - 1)) begin
                        resetnNext = 1'b0;
                        stateNext  = FLUSH;
                    end
                end
            end

            FLUSH: begin
                // Any late adder_done_i is ignored here. The adder is being
                // reset, so its result is discarded in favour of an error.
                resNext   = '0;
                errNext   = 1'b1;
                doneNext  = owner ? 2'b10 : 2'b01;
                stateNext = IDLE;
            end

            default: begin
                stateNext = IDLE;
            end
        endcase

        busyNext = (stateNext != IDLE);
    end

    // Control and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            waitCnt        <= '0;
            owner          <= 1'b0;
            lastGnt        <= 1'b1;
            gnt_o          <= 2'b00;
            done_o         <= 2'b00;
            res_o          <= '0;
            err_o          <= 1'b0;
            busy_o         <= 1'b0;
            adder_start_o  <= 1'b0;
            adder_resetn_o <= 1'b0;
        end else begin
            state          <= stateNext;
            waitCnt        <= waitCntNext;
            owner          <= ownerNext;
            lastGnt        <= lastGntNext;
            gnt_o          <= gntNext;
            done_o         <= doneNext;
            res_o          <= resNext;
            err_o          <= errNext;
            busy_o         <= busyNext;
            adder_start_o  <= startNext;
            adder_resetn_o <= resetnNext;
        end
    end

    // Operand latch. The adder applies sub combinationally on every chunk,
    // so a, b and sub change only when a new operation is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adder_a_o   <= '0;
            adder_b_o   <= '0;
            adder_sub_o <= 1'b0;
        end else if (latchEn) begin
            adder_a_o   <= winner ? a1_i : a0_i;
            adder_b_o   <= winner ? b1_i : b0_i;
            adder_sub_o <= sub_i[winner];
        end
    end

endmodule

// File: tb/tb_mpadder_arbiter.sv
module tb_mpadder_arbiter;

    localparam int OP_WIDTH = 1027;
    localparam int TIMEOUT  = 16;

    logic                clk;
    logic                rst;
    logic [1:0]          req_i;
    logic [1:0]          sub_i;
    logic [OP_WIDTH-1:0] a0_i;
    logic [OP_WIDTH-1:0] b0_i;
    logic [OP_WIDTH-1:0] a1_i;
    logic [OP_WIDTH-1:0] b1_i;
    logic [1:0]          gnt_o;
    logic [1:0]          done_o;
    logic [OP_WIDTH:0]   res_o;
    logic                err_o;
    logic                busy_o;
    logic                adder_start_o;
    logic                adder_sub_o;
    logic [OP_WIDTH-1:0] adder_a_o;
    logic [OP_WIDTH-1:0] adder_b_o;
    logic [OP_WIDTH:0]   adder_result_i;
    logic                adder_done_i;
    logic                adder_resetn_o;

    int testCnt = 0;
    int failCnt = 0;

    mpadder_arbiter #(
        .OP_WIDTH(OP_WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_i         (req_i),
        .sub_i         (sub_i),
        .a0_i          (a0_i),
        .b0_i          (b0_i),
        .a1_i          (a1_i),
        .b1_i          (b1_i),
        .gnt_o         (gnt_o),
        .done_o        (done_o),
        .res_o         (res_o),
        .err_o         (err_o),
        .busy_o        (busy_o),
        .adder_start_o (adder_start_o),
        .adder_sub_o   (adder_sub_o),
        .adder_a_o     (adder_a_o),
        .adder_b_o     (adder_b_o),
        .adder_result_i(adder_result_i),
        .adder_done_i  (adder_done_i),
        .adder_resetn_o(adder_resetn_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder stand-in with start-to-done latency 3. The result is computed
    // from the operands the arbiter presents while the operation runs.
    logic d1, d2, d3;
    logic adderEn;
    always @(posedge clk) begin
        if (!adder_resetn_o) begin
            d1 <= 1'b0;
            d2 <= 1'b0;
            d3 <= 1'b0;
        end else begin
            d1 <= adder_start_o;
            d2 <= d1;
            d3 <= d2;
        end
    end
    assign adder_done_i   = d3 & adderEn;
    assign adder_result_i = adder_sub_o ? ({1'b0, adder_a_o} - {1'b0, adder_b_o})
                                        : ({1'b0, adder_a_o} + {1'b0, adder_b_o});

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chkN(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCnt++;
        assert (obs === exp)
        else begin
            failCnt++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkW(input string tag, input logic [OP_WIDTH:0] obs, input logic [OP_WIDTH:0] exp);
        testCnt++;
        assert (obs === exp)
        else begin
            failCnt++;
            $error("FAIL %s: observed hi=%h lo=%h, expected hi=%h lo=%h", tag,
                   obs[OP_WIDTH:OP_WIDTH-63], obs[63:0], exp[OP_WIDTH:OP_WIDTH-63], exp[63:0]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    logic [OP_WIDTH:0] expWrap;
    logic              sawDone;

    initial begin
        expWrap = ~((OP_WIDTH+1)'(1));   // 3 - 5 mod 2^1028 = 2^1028 - 2
        rst     = 1'b1;
        req_i   = 2'b00;
        sub_i   = 2'b00;
        a0_i    = '0;
        b0_i    = '0;
        a1_i    = '0;
        b1_i    = '0;
        adderEn = 1'b1;

        // Reset state
        repeat (3) cyc();
        chkN("rst_gnt",    32'(gnt_o), 0);
        chkN("rst_done",   32'(done_o), 0);
        chkN("rst_busy",   32'(busy_o), 0);
        chkN("rst_err",    32'(err_o), 0);
        chkN("rst_start",  32'(adder_start_o), 0);
        chkN("rst_resetn", 32'(adder_resetn_o), 0);
        chkW("rst_res",    res_o, '0);
        rst = 1'b0;
        cyc();
        chkN("resetn_rise", 32'(adder_resetn_o), 1);
        chkN("idle_busy",   32'(busy_o), 0);

        // Single add: 5 + 3 by requester 0
        cyc();
        a0_i = 5; b0_i = 3; sub_i = 2'b00; req_i = 2'b01;
        cyc();                                         // cycle 1
        chkN("add_gnt",   32'(gnt_o), 1);
        chkN("add_start", 32'(adder_start_o), 1);
        chkN("add_busy",  32'(busy_o), 1);
        req_i = 2'b00;
        cyc();                                         // cycle 2
        chkN("add_gnt_pulse", 32'(gnt_o), 0);
        chkN("add_a_hold",    32'(adder_a_o), 5);
        cyc(); cyc();                                  // cycle 4
        chkN("add_done_early", 32'(done_o), 0);
        cyc();                                         // cycle 5
        chkN("add_done", 32'(done_o), 1);
        chkW("add_res",  res_o, (OP_WIDTH+1)'(8));
        chkN("add_err",  32'(err_o), 0);
        chkN("add_idle", 32'(busy_o), 0);
        cyc();
        chkN("add_done_pulse", 32'(done_o), 0);
        chkW("add_res_hold",   res_o, (OP_WIDTH+1)'(8));

        // Subtract: 5 - 3 by requester 1, sub held through WAIT
        a1_i = 5; b1_i = 3; sub_i = 2'b10; req_i = 2'b10;
        cyc();                                         // cycle 1
        chkN("sub_gnt", 32'(gnt_o), 2);
        chkN("sub_op1", 32'(adder_sub_o), 1);
        req_i = 2'b00; sub_i = 2'b00;
        cyc();
        chkN("sub_op2", 32'(adder_sub_o), 1);
        cyc();
        chkN("sub_op3", 32'(adder_sub_o), 1);
        cyc();
        chkN("sub_op4", 32'(adder_sub_o), 1);
        cyc();                                         // cycle 5
        chkN("sub_done", 32'(done_o), 2);
        chkW("sub_res",  res_o, (OP_WIDTH+1)'(2));

        // Round robin: both requesting continuously
        cyc();
        a0_i = 5; b0_i = 3; a1_i = 5; b1_i = 3; sub_i = 2'b10; req_i = 2'b11;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chkN("rr_gnt", 32'(gnt_o), (k % 2 == 1) ? 2 : 1);
            repeat (3) cyc();
            cyc();
            chkN("rr_done", 32'(done_o), (k % 2 == 1) ? 2 : 1);
            chkW("rr_res",  res_o, (k % 2 == 1) ? (OP_WIDTH+1)'(2) : (OP_WIDTH+1)'(8));
        end
        req_i = 2'b00;
        cyc();
        chkN("rr_stop_gnt", 32'(gnt_o), 0);
        chkN("rr_stop_busy", 32'(busy_o), 0);

        // Operand latching: a0 changes in the gnt cycle
        a0_i = 7; b0_i = 1; sub_i = 2'b00; req_i = 2'b01;
        cyc();
        chkN("latch_gnt", 32'(gnt_o), 1);
        a0_i = 100; req_i = 2'b00;
        cyc();
        chkN("latch_a", 32'(adder_a_o), 7);
        repeat (2) cyc();
        cyc();
        chkN("latch_done", 32'(done_o), 1);
        chkW("latch_res",  res_o, (OP_WIDTH+1)'(8));

        // Wrapping subtraction: 3 - 5 by requester 1
        cyc();
        a1_i = 3; b1_i = 5; sub_i = 2'b10; req_i = 2'b10;
        cyc();
        chkN("wrap_gnt", 32'(gnt_o), 2);
        req_i = 2'b00;
        repeat (3) cyc();
        cyc();
        chkN("wrap_done", 32'(done_o), 2);
        chkW("wrap_res",  res_o, expWrap);

        // Timeout: adder never answers
        cyc();
        adderEn = 1'b0;
        a0_i = 5; b0_i = 3; sub_i = 2'b00; req_i = 2'b01;
        cyc();                                         // cycle 1
        chkN("to_gnt", 32'(gnt_o), 1);
        req_i = 2'b00;
        repeat (16) cyc();                             // cycle 17, last WAIT
        chkN("to_resetn_wait", 32'(adder_resetn_o), 1);
        chkN("to_done_wait",   32'(done_o), 0);
        cyc();                                         // cycle 18, FLUSH
        chkN("to_resetn_flush", 32'(adder_resetn_o), 0);
        chkN("to_busy_flush",   32'(busy_o), 1);
        chkN("to_done_flush",   32'(done_o), 0);
        cyc();                                         // cycle 19
        chkN("to_resetn_after", 32'(adder_resetn_o), 1);
        chkN("to_done", 32'(done_o), 1);
        chkN("to_err",  32'(err_o), 1);
        chkW("to_res",  res_o, '0);
        adderEn = 1'b1;

        // Next request after a timeout completes normally
        cyc();
        a0_i = 5; b0_i = 3; sub_i = 2'b00; req_i = 2'b01;
        cyc();
        chkN("post_to_gnt", 32'(gnt_o), 1);
        req_i = 2'b00;
        repeat (3) cyc();
        cyc();
        chkN("post_to_done", 32'(done_o), 1);
        chkN("post_to_err",  32'(err_o), 0);
        chkW("post_to_res",  res_o, (OP_WIDTH+1)'(8));

        // Reset mid-operation
        cyc();
        a0_i = 5; b0_i = 3; sub_i = 2'b00; req_i = 2'b01;
        cyc();                                         // cycle 1
        req_i = 2'b00;
        cyc(); cyc();                                  // cycle 3, in WAIT
        rst = 1'b1;
        #1;
        chkN("mid_busy",   32'(busy_o), 0);
        chkN("mid_resetn", 32'(adder_resetn_o), 0);
        chkN("mid_a",      32'(adder_a_o), 0);
        chkN("mid_done",   32'(done_o), 0);
        chkW("mid_res",    res_o, '0);
        cyc();
        rst = 1'b0;
        sawDone = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            sawDone = sawDone | (|done_o);
        end
        chkN("mid_no_done", 32'(sawDone), 0);

        // Requester 0 wins the first tie after reset
        a0_i = 5; b0_i = 3; a1_i = 5; b1_i = 3; sub_i = 2'b10; req_i = 2'b11;
        cyc();
        chkN("mid_prio_gnt", 32'(gnt_o), 1);
        req_i = 2'b00;
        repeat (3) cyc();
        cyc();
        chkN("mid_prio_done", 32'(done_o), 1);
        chkW("mid_prio_res",  res_o, (OP_WIDTH+1)'(8));

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule
